game_controller: RTL
====================

Name: game_controller

Overview:
- Top-level game sequencer for the frog-crossing game.
- Owns the game FSM (idle, play, death, level-up, game over), lives, level and score.
- Drives the player datapath's reset and movement enable, and generates the level-dependent lane step tick consumed by the obstacle sprites.
- Sits between the player/obstacle sprite modules and the 7-segment/VGA display logic.

Parameters:
- LIVES, 3, lives granted at game start (1..3).
- MAX_LEVEL, 9, highest level; level saturates here.
- GOAL_ROW, 0, player row that counts as a crossing.
- HOLD_CYCLES, 12_500_000, length of the DEATH and LEVEL_UP freeze, in i_Clk cycles (0.5 s at 25 MHz).
- BASE_TICK_CYCLES, 6_250_000, lane tick period at level 1.
- TICK_STEP_CYCLES, 625_000, period reduction per level above 1.
- MIN_TICK_CYCLES, 1_250_000, floor on the lane tick period.

Ports:
- i_Clk  in  1  system clock (25 MHz).
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  debounced start button level; rising edge detected internally.
- i_player_y  in  4  current player row.
- i_collision  in  1  player overlaps an obstacle this cycle.
- o_player_reset  out  1  one-cycle pulse that returns the player to origin.
- o_move_en  out  1  player input accepted when 1.
- o_lane_tick  out  1  one-cycle obstacle step pulse.
- o_level  out  4  current level, 1..MAX_LEVEL.
- o_lives  out  2  remaining lives.
- o_score  out  8  score, saturating.
- o_state  out  3  FSM state encoding, for display.

Behaviour:
- Clocking and reset: one clock, i_Clk. Reset is asynchronous and active-high on i_reset, effective immediately, including mid-game.
- Reset values: state=IDLE, o_player_reset=0, o_move_en=0, o_lane_tick=0, o_level=1, o_lives=0, o_score=0, tick counter=0, hold counter=0, start edge register=0.
- All outputs are registered. Response latency is 1 cycle after the qualifying input is sampled.
- start_pulse = i_start & ~i_start_d, where i_start_d is i_start registered.
- IDLE and GAME_OVER:
  - o_move_en=0; tick frozen.
  - On start_pulse: enter PLAY; lives=LIVES; level=1; score=0; tick counter=0; o_player_reset=1 for 1 cycle.
  - GAME_OVER keeps the final score and level displayed until start_pulse.
- PLAY:
  - o_move_en=1; tick counter runs.
  - Collision: i_collision=1 → lives-1. If lives was 1, go to GAME_OVER (lives=0). Otherwise go to DEATH.
  - Goal: i_player_y==GOAL_ROW with no collision → score += level, saturating at 255; level += 1, saturating at MAX_LEVEL; go to LEVEL_UP.
  - Collision has priority over goal in the same cycle.
  - Goal detection must work when the row is present for a single cycle, because the player datapath self-resets at row 0.
- DEATH and LEVEL_UP:
  - o_player_reset=1 on the first cycle in the state; o_move_en=0; tick frozen.
  - Hold counter counts HOLD_CYCLES, then returns to PLAY.
  - LEVEL_UP also clears the tick counter.
  - i_collision and i_start are ignored in these states.
- Lane tick:
  - period = max(MIN_TICK_CYCLES, BASE_TICK_CYCLES - (level-1)*TICK_STEP_CYCLES).
  - Compute in unsigned arithmetic with underflow clamped to MIN_TICK_CYCLES.
  - Counter width = $clog2(BASE_TICK_CYCLES+1).
  - Counter counts 0..period-1. o_lane_tick=1 for one cycle when counter==period-1, then counter wraps to 0.
  - A new period takes effect from the next wrap.
- State encoding: IDLE=0, PLAY=1, DEATH=2, LEVEL_UP=3, GAME_OVER=4 (PAUSE=5 when the optional feature is compiled in).

Optional Feature:
- Macro: GAME_CONTROLLER_PAUSE_EN.
- When defined:
  - Adds input port i_pause (1 bit, debounced, rising edge detected internally).
  - In PLAY, an i_pause rising edge enters PAUSE: o_move_en=0, tick counter held, collisions and goal ignored.
  - The next rising edge returns to PLAY with the counter value preserved.
  - i_pause is ignored in all other states.
- When undefined: no i_pause port, no PAUSE state, encoding 5 unused.

Decomposition:
- game_pkg contains:
  - state encodings;
  - level/lives/score widths;
  - GOAL_ROW and the origin coordinates (11, 14), shared with the player sprite.
- One sub-module, lane_tick_gen, contains:
  - inputs: i_Clk, i_reset, i_run, i_clear, i_period;
  - output: o_tick;
  - the prescaler and the period clamp.
- FSM, lives, level and score stay in game_controller.

Test Plan:
All scenarios use HOLD_CYCLES=8, BASE_TICK_CYCLES=20, TICK_STEP_CYCLES=4, MIN_TICK_CYCLES=4.
- Start: i_start 0→1 in IDLE → next cycle state=PLAY, o_player_reset pulse of 1 cycle, o_lives=3, o_level=1, o_move_en=1; o_lane_tick every 20 cycles.
- Goal: in PLAY at level 1, i_player_y=0 for 1 cycle → LEVEL_UP, o_score=1, o_level=2, o_move_en=0 for 8 cycles, then PLAY; tick period 16.
- Period floor: drive level to 6 → tick period 4 (clamped); level stops at 9 after further goals; score saturates at 255.
- Death and game over: three collisions → lives 3→2→1 with a DEATH hold of 8 cycles each time; third collision → GAME_OVER, o_lives=0, tick frozen; start_pulse restarts with lives=3.
- Priority: i_collision=1 and i_player_y=0 in the same cycle → DEATH, score unchanged.
- Async reset: assert i_reset mid-DEATH (hold count 4) → outputs at reset values the same cycle without a clock edge; deassert → IDLE; holding i_start high does not restart until a new rising edge.

Source files
------------

// File: rtl/game_pkg.sv
// ============================================================================
// game_pkg : shared types, widths and playfield constants for the frog game
// Rev 1.0  initial release
// ============================================================================
`default_nettype none

package game_pkg;

  localparam int LEVEL_W = 4;
  localparam int LIVES_W = 2;
  localparam int SCORE_W = 8;
  localparam int ROW_W   = 4;
  localparam int STATE_W = 3;

  localparam logic [ROW_W-1:0] GOAL_ROW = 4'd0;
  localparam logic [3:0]       ORIGIN_X = 4'd11;
  localparam logic [3:0]       ORIGIN_Y = 4'd14;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DEATH     = 3'd2,
    ST_LEVEL_UP  = 3'd3,
`ifdef GAME_CONTROLLER_PAUSE_EN
    ST_GAME_OVER = 3'd4,
    ST_PAUSE     = 3'd5
`else
    ST_GAME_OVER = 3'd4
`endif
  } state_t;

  function automatic logic [SCORE_W-1:0] sat_add_score(
    input logic [SCORE_W-1:0] score,
    input logic [LEVEL_W-1:0] level
  );
    logic [SCORE_W:0] sum;
    sum = {1'b0, score} + {{(SCORE_W + 1 - LEVEL_W){1'b0}}, level};
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_controller_lane_tick_gen.sv
// ============================================================================
// lane_tick_gen : level-dependent obstacle step prescaler with period floor
// Rev 1.0  initial release
// ============================================================================
`default_nettype none

module lane_tick_gen
  import game_pkg::*;
#(
  parameter int unsigned BASE_TICK_CYCLES = 6_250_000,
  parameter int unsigned TICK_STEP_CYCLES = 625_000,
  parameter int unsigned MIN_TICK_CYCLES  = 1_250_000
)(
  input  logic               i_Clk,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic               i_clear,
  input  logic [LEVEL_W-1:0] i_period,
  output logic               o_tick
);

  localparam int CNT_W = $clog2(BASE_TICK_CYCLES + 1);

  logic [31:0]      reduction;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_last;
  logic             tick;

  // i_period carries the level; level 1 maps to the base period.
  always_comb begin
    reduction = (i_period == '0) ? 32'd0
              : (32'(i_period) - 32'd1) * TICK_STEP_CYCLES;
    if (reduction >= BASE_TICK_CYCLES ||
        (BASE_TICK_CYCLES - reduction) < MIN_TICK_CYCLES) begin
      period = CNT_W'(MIN_TICK_CYCLES);
    end else begin
      period = CNT_W'(BASE_TICK_CYCLES - reduction);
    end
    count_last = period - 1'b1;
  end

  // Level only changes while the count is cleared, so a new period always
  // starts from a fresh count.
  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (i_clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (i_run) begin
      if (count >= count_last) begin
        count <= '0;
        tick  <= 1'b1;
      end else begin
        count <= count + 1'b1;
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  assign o_tick = tick;

endmodule

`default_nettype wire

// File: rtl/game_controller.sv
// ============================================================================
// game_controller : game FSM, lives/level/score and lane tick for frog game
// Optional pause state enabled by defining GAME_CONTROLLER_PAUSE_EN.
// Rev 1.0  initial release
// ============================================================================
`default_nettype none

module game_controller
  import game_pkg::*;
#(
  parameter int          LIVES            = 3,
  parameter int          MAX_LEVEL        = 9,
  parameter logic [3:0]  GOAL_ROW         = game_pkg::GOAL_ROW,
  parameter int unsigned HOLD_CYCLES      = 12_500_000,
  parameter int unsigned BASE_TICK_CYCLES = 6_250_000,
  parameter int unsigned TICK_STEP_CYCLES = 625_000,
  parameter int unsigned MIN_TICK_CYCLES  = 1_250_000
)(
  input  logic       i_Clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [3:0] i_player_y,
  input  logic       i_collision,
`ifdef GAME_CONTROLLER_PAUSE_EN
  input  logic       i_pause,
`endif
  output logic       o_player_reset,
  output logic       o_move_en,
  output logic       o_lane_tick,
  output logic [3:0] o_level,
  output logic [1:0] o_lives,
  output logic [7:0] o_score,
  output logic [2:0] o_state
);

  localparam int                 HOLD_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  state_t             state, state_next;
  logic [LIVES_W-1:0] lives, lives_next;
  logic [LEVEL_W-1:0] level, level_next;
  logic [SCORE_W-1:0] score, score_next;
  logic [HOLD_W-1:0]  hold_cnt, hold_next;
  logic               player_reset, player_reset_next;
  logic               move_en;
  logic               clear_tick;
  logic               start_d;
  logic               start_pulse;
  logic               goal;

  assign start_pulse = i_start & ~start_d;
  assign goal        = (i_player_y == GOAL_ROW) && !i_collision;

`ifdef GAME_CONTROLLER_PAUSE_EN
  logic pause_d;
  logic pause_pulse;

  assign pause_pulse = i_pause & ~pause_d;

  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      pause_d <= 1'b0;
    end else begin
      pause_d <= i_pause;
    end
  end
`endif

  always_comb begin
    state_next        = state;
    lives_next        = lives;
    level_next        = level;
    score_next        = score;
    hold_next         = hold_cnt;
    player_reset_next = 1'b0;
    clear_tick        = 1'b0;
    case (state)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_pulse) begin
          state_next        = ST_PLAY;
          lives_next        = LIVES_INIT;
          level_next        = LEVEL_W'(1);
          score_next        = '0;
          player_reset_next = 1'b1;
          clear_tick        = 1'b1;
        end
      end
      ST_PLAY: begin
        if (i_collision) begin
          hold_next = '0;
          if (lives <= LIVES_W'(1)) begin
            state_next = ST_GAME_OVER;
            lives_next = '0;
          end else begin
            state_next        = ST_DEATH;
            lives_next        = lives - 1'b1;
            player_reset_next = 1'b1;
          end
        end else if (goal) begin
          state_next        = ST_LEVEL_UP;
          score_next        = sat_add_score(score, level);
          level_next        = (level >= LEVEL_MAX) ? level : level + 1'b1;
          hold_next         = '0;
          player_reset_next = 1'b1;
          clear_tick        = 1'b1;
        end
`ifdef GAME_CONTROLLER_PAUSE_EN
        else if (pause_pulse) begin
          state_next = ST_PAUSE;
        end
`endif
      end
      ST_DEATH, ST_LEVEL_UP: begin
        if (hold_cnt >= HOLD_LAST) begin
          state_next = ST_PLAY;
          hold_next  = '0;
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end
`ifdef GAME_CONTROLLER_PAUSE_EN
      ST_PAUSE: begin
        if (pause_pulse) begin
          state_next = ST_PLAY;
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      lives        <= '0;
      level        <= LEVEL_W'(1);
      score        <= '0;
      hold_cnt     <= '0;
      start_d      <= 1'b0;
      player_reset <= 1'b0;
      move_en      <= 1'b0;
    end else begin
      state        <= state_next;
      lives        <= lives_next;
      level        <= level_next;
      score        <= score_next;
      hold_cnt     <= hold_next;
      start_d      <= i_start;
      player_reset <= player_reset_next;
      move_en      <= (state_next == ST_PLAY);
    end
  end

  lane_tick_gen #(
    .BASE_TICK_CYCLES (BASE_TICK_CYCLES),
    .TICK_STEP_CYCLES (TICK_STEP_CYCLES),
    .MIN_TICK_CYCLES  (MIN_TICK_CYCLES)
  ) u_lane_tick_gen (
    .i_Clk    (i_Clk),
    .i_reset  (i_reset),
    .i_run    (state == ST_PLAY),
    .i_clear  (clear_tick),
    .i_period (level),
    .o_tick   (o_lane_tick)
  );

  assign o_player_reset = player_reset;
  assign o_move_en      = move_en;
  assign o_level        = level;
  assign o_lives        = lives;
  assign o_score        = score;
  assign o_state        = state;

endmodule

`default_nettype wire
